aes256_scan_ctrl: RTL

Sequencing controller for the AES-256 key schedule pipeline in the key finder.
- Accepts a stream of 128-bit memory words and forms overlapping 256-bit key candidates from consecutive word pairs.
- Issues one candidate per accepted word to the 13-stage schedule pipeline.
- Carries each candidate's address alongside through a matching tag delay line.
- Collects hit indications from the downstream comparator and reports the first hit address plus a hit count when the scan completes.

---
 rtl/aes_scan_pkg.sv | 33 +++
 rtl/aes_scan_tag_delay.sv | 37 +++
 rtl/aes256_scan_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/aes_scan_pkg.sv
// Shared types and constants for the AES-256 key-candidate scan controller.
package aes_scan_pkg;

  localparam int WORD_W          = 128;
  localparam int ADDR_STEP       = 16;
  localparam int DEFAULT_LATENCY = 13;
  localparam int TAG_ADDR_W      = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic [TAG_ADDR_W-1:0] addr;
    logic                  last;
  } tag_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/aes_scan_tag_delay.sv
// Tag delay line that tracks each candidate through the key schedule pipeline.
// flush empties every stage so cancelled candidates never reach the output.
module aes_scan_tag_delay
  import aes_scan_pkg::*;
#(
  parameter int DEPTH = DEFAULT_LATENCY
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  tag_t din,
  output tag_t dout
);

  tag_t pipe_r [DEPTH];

  // Shift register of tags, cleared by reset or flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_r[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_r[i] <= '0;
      end
    end else begin
      pipe_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign dout = pipe_r[DEPTH-1];

endmodule

// File: rtl/aes256_scan_ctrl.sv
// Scan controller: pairs consecutive 128-bit words into AES-256 key candidates,
// tags them through the schedule latency and gathers comparator hits.
// Optional macro AES_SCAN_STOP_ON_HIT_EN stops consuming words after the first hit.
module aes256_scan_ctrl
  import aes_scan_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  input  logic              s_valid,
  input  logic [WORD_W-1:0] s_data,
  output logic              s_ready,
  output logic [WORD_W-1:0] key_hi,
  output logic [WORD_W-1:0] key_lo,
  output logic              res_valid,
  output logic [ADDR_W-1:0] res_addr,
  output logic              res_last,
  input  logic              hit,
  output logic              busy,
  output logic              done,
  output logic              hit_found,
  output logic [ADDR_W-1:0] hit_addr,
  output logic [15:0]       hit_count
);

  localparam int CNT_W = $clog2(LATENCY + 2);

  state_t              state_r;
  state_t              state_s;
  logic                ready_r;
  logic                busy_r;
  logic                done_r;
  logic [ADDR_W-1:0]   addr_cnt_r;
  logic [ADDR_W-1:0]   remain_r;
  logic [WORD_W-1:0]   prev_r;
  logic [WORD_W-1:0]   key_hi_r;
  logic [WORD_W-1:0]   key_lo_r;
  tag_t                tag_in_s;
  tag_t                tag_r;
  tag_t                tag_out_s;
  logic [CNT_W-1:0]    inflight_r;
  logic                hit_found_r;
  logic [ADDR_W-1:0]   hit_addr_r;
  logic [15:0]         hit_count_r;

  logic accept_s;
  logic abort_s;
  logic issue_s;
  logic retire_s;
  logic last_word_s;
  logic capture_s;
  logic first_hit_s;

  assign accept_s    = s_valid && ready_r;
  assign abort_s     = abort && (state_r != ST_IDLE);
  assign issue_s     = accept_s && (state_r == ST_RUN) && !abort_s;
  assign retire_s    = tag_out_s.valid;
  assign last_word_s = (remain_r == ADDR_W'(1));
  assign capture_s   = hit && tag_out_s.valid && !abort_s &&
                       ((state_r == ST_RUN) || (state_r == ST_DRAIN));
  assign first_hit_s = capture_s && !hit_found_r;

  // Next-state decode; abort overrides every other transition.
  always_comb begin
    state_s = state_r;
    if (abort_s) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if (num_words < ADDR_W'(2)) begin
              state_s = ST_DONE;
            end else begin
              state_s = ST_PRIME;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_PRIME: begin
          if (accept_s) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_PRIME;
          end
        end
        ST_RUN: begin
          if (accept_s && last_word_s) begin
            state_s = ST_DRAIN;
`ifdef AES_SCAN_STOP_ON_HIT_EN
          end else if (first_hit_s) begin
            state_s = ST_DRAIN;
`endif
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (inflight_r == '0) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_DRAIN;
          end
        end
        ST_DONE: state_s = ST_IDLE;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // State register; status outputs are registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      ready_r <= (state_s == ST_PRIME) || (state_s == ST_RUN);
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= (state_s == ST_DONE);
    end
  end

  // Address/remaining counters and the overlapping key-pair datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_cnt_r <= '0;
      remain_r   <= '0;
      prev_r     <= '0;
      key_hi_r   <= '0;
      key_lo_r   <= '0;
    end else if ((state_r == ST_IDLE) && start) begin
      addr_cnt_r <= base_addr;
      remain_r   <= num_words;
    end else if (accept_s && !abort_s) begin
      remain_r <= remain_r - ADDR_W'(1);
      prev_r   <= s_data;
      if (state_r == ST_RUN) begin
        key_hi_r   <= prev_r;
        key_lo_r   <= s_data;
        addr_cnt_r <= addr_cnt_r + ADDR_W'(ADDR_STEP);
      end
    end
  end

  // Tag for the candidate being loaded into the key registers this edge.
  always_comb begin
    tag_in_s = '0;
    if (issue_s) begin
      tag_in_s.valid = 1'b1;
      tag_in_s.addr  = TAG_ADDR_W'(addr_cnt_r);
      tag_in_s.last  = last_word_s;
    end else begin
      tag_in_s = '0;
    end
  end

  // Tag register aligned with key_hi/key_lo; the delay line adds LATENCY more.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_r <= '0;
    end else begin
      tag_r <= tag_in_s;
    end
  end

  aes_scan_tag_delay #(
    .DEPTH (LATENCY)
  ) u_tag_delay (
    .clk   (clk),
    .rst   (rst),
    .flush (abort_s),
    .din   (tag_r),
    .dout  (tag_out_s)
  );

  // Candidates issued but not yet seen at the pipeline output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_r <= '0;
    end else if (abort_s) begin
      inflight_r <= '0;
    end else if (issue_s && !retire_s) begin
      inflight_r <= inflight_r + CNT_W'(1);
    end else if (!issue_s && retire_s) begin
      inflight_r <= inflight_r - CNT_W'(1);
    end
  end

  // Hit collection; only the first hit of a scan sets the reported address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_found_r <= 1'b0;
      hit_addr_r  <= '0;
      hit_count_r <= '0;
    end else if ((state_r == ST_IDLE) && start) begin
      hit_found_r <= 1'b0;
      hit_addr_r  <= '0;
      hit_count_r <= '0;
    end else if (capture_s) begin
      hit_count_r <= sat_inc16(hit_count_r);
      if (first_hit_s) begin
        hit_found_r <= 1'b1;
        hit_addr_r  <= res_addr;
      end
    end
  end

  assign s_ready   = ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign key_hi    = key_hi_r;
  assign key_lo    = key_lo_r;
  assign res_valid = tag_out_s.valid;
  assign res_addr  = ADDR_W'(tag_out_s.addr);
  assign res_last  = tag_out_s.last;
  assign hit_found = hit_found_r;
  assign hit_addr  = hit_addr_r;
  assign hit_count = hit_count_r;

endmodule
